// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port (audio, FFT) arbiter for one async SRAM, audio has fixed priority.
// Latency 3 cycles (IDLE/ACCESS/DONE); requesters hold req until ack; FFT starvation guard under SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_a_req,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic              i_a_we,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic              o_a_ack,
  output logic [DATA_W-1:0] o_a_rdata,
  input  logic              i_f_req,
  input  logic [ADDR_W-1:0] i_f_addr,
  input  logic              i_f_we,
  input  logic [DATA_W-1:0] i_f_wdata,
  output logic              o_f_ack,
  output logic [DATA_W-1:0] o_f_rdata,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N,
  output logic              o_owner,
  output logic              o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t            state, state_nxt;
  logic              grant_vld;
  logic              grant_f;
  logic              starve_hit;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic              access_wr;
  logic              access_rd;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 2);
  logic [CNT_W-1:0] starve_cnt;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Counts audio grants that overtook a waiting FFT request.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (!i_f_req || grant_f)
        starve_cnt <= '0;
      else if (grant_vld)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict audio priority: the guard never fires.
  assign starve_hit = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_f   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_f_req && (!i_a_req || starve_hit)) begin
          grant_vld = 1'b1;
          grant_f   = 1'b1;
        end else if (i_a_req) begin
          grant_vld = 1'b1;
        end
        if (grant_vld)
          state_nxt = S_ACCESS;
      end
      S_ACCESS: state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request fields are frozen at grant so the SRAM cycle ignores later changes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_owner   <= 1'b0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else if (grant_vld) begin
      o_owner   <= grant_f;
      lat_addr  <= grant_f ? i_f_addr  : i_a_addr;
      lat_we    <= grant_f ? i_f_we    : i_a_we;
      lat_wdata <= grant_f ? i_f_wdata : i_a_wdata;
    end
  end

  // Read data is sampled at the end of ACCESS so it is valid alongside the DONE ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_a_ack   <= 1'b0;
      o_f_ack   <= 1'b0;
      o_a_rdata <= '0;
      o_f_rdata <= '0;
    end else begin
      o_a_ack <= (state == S_ACCESS) && !o_owner;
      o_f_ack <= (state == S_ACCESS) &&  o_owner;
      if (access_rd) begin
        if (o_owner)
          o_f_rdata <= io_SRAM_DQ;
        else
          o_a_rdata <= io_SRAM_DQ;
      end
    end
  end

  assign access_wr   = (state == S_ACCESS) &&  lat_we;
  assign access_rd   = (state == S_ACCESS) && !lat_we;

  assign o_SRAM_ADDR = lat_addr;
  assign o_SRAM_WE_N = !access_wr;
  assign o_SRAM_OE_N = !access_rd;
  assign o_SRAM_CE_N = i_rst;
  assign o_SRAM_LB_N = i_rst;
  assign o_SRAM_UB_N = i_rst;
  assign io_SRAM_DQ  = access_wr ? lat_wdata : {DATA_W{1'bz}};
  assign o_busy      = (state != S_IDLE);

endmodule
